cnn_frame_feeder: RTL and testbench
===================================

Name: cnn_frame_feeder

Overview:
Upstream driver for cnn_core_top. Buffers one 28x28 u8 image arriving as a byte stream with ready/valid flow control, then streams it into the core as 784 back-to-back data_valid cycles. Waits for the core's out_valid and latches decision. Returns the result to the host over a valid/ready handshake. Sits between the host/UART byte path and cnn_core_top.

Parameters:
IMG_PIXELS, 784, pixels per frame; the core requires an unbroken burst of exactly this many.
ADDR_W, 10, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_PIXELS.
TIMEOUT_CYC, 5000, WAIT-state cycle limit; used only with FEEDER_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_data  in  8  host pixel byte
wr_valid  in  1  host byte valid
wr_ready  out  1  feeder can accept a byte
data_in  out  8  pixel to cnn_core_top.data_in
data_valid  out  1  to cnn_core_top.data_valid
core_decision  in  4  from cnn_core_top.decision
core_out_valid  in  1  from cnn_core_top.out_valid
result_data  out  4  latched class, 0..9; 4'hF on timeout
result_valid  out  1  result available
result_ready  in  1  host consumes result
result_timeout  out  1  result produced by timeout
busy  out  1  high in every state except LOAD

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=LOAD, wr_ptr=0, rd_ptr=0, wr_ready=1, data_valid=0, data_in=0, result_valid=0, result_data=0, result_timeout=0, busy=0.
- Frame buffer: IMG_PIXELS x 8 synchronous-read RAM. It is not reset and contents are don't-care after reset.
- LOAD state:
  - wr_ready=1.
  - Each cycle with wr_valid&&wr_ready writes buf[wr_ptr] and increments wr_ptr. Gaps in wr_valid are allowed.
  - On the accept at wr_ptr==IMG_PIXELS-1: next state=STREAM, wr_ptr clears to 0, and wr_ready drops on the following cycle.
- STREAM state:
  - rd_ptr walks 0..IMG_PIXELS-1, one address per cycle.
  - data_in and data_valid are registered. The first data_valid appears on the 2nd rising edge after the edge that captured the last byte (RAM read plus output register).
  - data_valid stays high exactly IMG_PIXELS consecutive cycles with no bubbles, carrying buf[0]..buf[IMG_PIXELS-1] in order.
  - After the last pixel: data_valid=0, data_in=0, rd_ptr=0, next state=WAIT.
- WAIT state:
  - On core_out_valid=1, result_data<=core_decision and result_timeout<=0, then go to RESULT.
  - core_out_valid in any other state is ignored.
- RESULT state:
  - result_valid=1, and result_data stays stable while result_ready=0.
  - On result_valid&&result_ready: result_valid drops next cycle and state returns to LOAD, with wr_ready=1 the same cycle result_valid drops.
- Bytes are never accepted outside LOAD; wr_ready=0 in STREAM, WAIT and RESULT.
- Reset mid-operation: any state aborts immediately (async). data_valid and result_valid go low without waiting for a clock, and the partial frame is discarded.
- Pointer widths: ADDR_W bits. wr_ptr and rd_ptr never exceed IMG_PIXELS-1, with no wrap beyond that.

Optional Feature:
FEEDER_TIMEOUT_EN:
- Defined:
  - A counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT_CYC without core_out_valid: result_data<=4'hF, result_timeout<=1, go to RESULT.
  - If core_out_valid arrives on the same cycle the count expires, core_out_valid wins and the normal result is taken.
- Undefined: no counter is built, WAIT waits indefinitely, and result_timeout is tied to 0.

Test Plan:
1. Reset -> wr_ready=1, data_valid=0, result_valid=0, busy=0. Assert rst_n=0 for 5 cycles mid-stream at pixel 300 -> data_valid=0 asynchronously; after release, state is LOAD and wr_ready=1.
2. Continuous writes of wr_data=i[7:0] for i=0..783 -> data_valid starts 2 edges after the last write and stays high 784 consecutive cycles. data_in runs 00..FF three times then 00..0F, ending at 0x0F.
3. Writes with wr_valid toggling every other cycle, plus random gaps -> identical 784-cycle output burst. wr_ready=0 for the whole STREAM/WAIT/RESULT period, and bytes offered then are not written.
4. In WAIT, drive core_out_valid 1 cycle with core_decision=7, result_ready=0 for 10 cycles -> result_valid=1 and result_data=7 held stable. Then pulse result_ready -> result_valid=0 and wr_ready=1 next cycle.
5. Pulse core_out_valid with decision 3 during STREAM -> ignored. A later WAIT pulse with decision 5 yields result_data=5.
6. With FEEDER_TIMEOUT_EN defined and TIMEOUT_CYC=100, no core_out_valid -> result_valid rises 100 cycles into WAIT with result_data=4'hF and result_timeout=1. Without the macro -> result_valid stays 0 after 1000 cycles.

Source files
------------

// File: rtl/cnn_frame_feeder.sv
// cnn_frame_feeder: buffers one IMG_PIXELS u8 frame from the host byte stream,
// bursts it into cnn_core_top back-to-back, captures the core decision and
// hands it to the host over valid/ready.
// Optional macro FEEDER_TIMEOUT_EN: bounds the WAIT state to TIMEOUT_CYC
// cycles and reports class 4'hF with result_timeout=1 on expiry.
module cnn_frame_feeder #(
  parameter int IMG_PIXELS  = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] data_in,
  output logic       data_valid,
  input  logic [3:0] core_decision,
  input  logic       core_out_valid,
  output logic [3:0] result_data,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       result_timeout,
  output logic       busy
);

  // one stage of RAM read latency, one of output register
  localparam int STAGES = 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT, RESULT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_done;
  logic [STAGES:0]   vld_pipe;
  logic [7:0]        mem [IMG_PIXELS];
  logic [7:0]        ram_q;
  logic              wr_acc, rd_en, stream_end, tmo_hit;

  assign wr_acc     = (state == LOAD) && wr_valid;
  assign rd_en      = (state == STREAM) && !rd_done;
  // last pixel is on the output and nothing is left in the RAM stage
  assign stream_end = (state == STREAM) && rd_done && vld_pipe[STAGES] && !vld_pipe[0];

  assign wr_ready     = (state == LOAD);
  assign busy         = (state != LOAD);
  assign result_valid = (state == RESULT);
  assign data_valid   = vld_pipe[STAGES];

`ifdef FEEDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_q;

  assign tmo_hit        = (state == WAIT) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign result_timeout = tmo_q;

  // WAIT-cycle counter, held at zero outside WAIT so it restarts on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state != WAIT)  tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  // timeout flag travels with the latched result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               tmo_q <= 1'b0;
    else if (state == WAIT && core_out_valid) tmo_q <= 1'b0;
    else if (tmo_hit)                         tmo_q <= 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo     = (TIMEOUT_CYC != 0);
  assign tmo_hit        = 1'b0;
  assign result_timeout = 1'b0;
`endif

  // frame buffer: not reset, synchronous read
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
    if (rd_en)  ram_q <= mem[rd_ptr];
  end

  // write pointer: advances per accepted byte, clears after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_ptr <= '0;
    else if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  end

  // read pointer walks the frame once; rd_done marks the last read issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_done <= 1'b0;
    end else if (rd_en) begin
      if (rd_ptr == LAST) begin
        rd_ptr  <= '0;
        rd_done <= 1'b1;
      end else begin
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end else if (stream_end) begin
      rd_done <= 1'b0;
    end
  end

  // valid shift register and zero-when-idle output data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      data_in  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
      data_in  <= vld_pipe[STAGES-1] ? ram_q : 8'h00;
    end
  end

  // result latch: core decision wins over a coincident timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               result_data <= 4'h0;
    else if (state == WAIT && core_out_valid) result_data <= core_decision;
    else if (tmo_hit)                         result_data <= 4'hF;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (wr_acc && wr_ptr == LAST)    state_nxt = STREAM;
      STREAM:  if (stream_end)                  state_nxt = WAIT;
      WAIT:    if (core_out_valid || tmo_hit)   state_nxt = RESULT;
      RESULT:  if (result_ready)                state_nxt = LOAD;
      default:                                  state_nxt = LOAD;
    endcase
  end

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Scoreboard bench for cnn_frame_feeder: stimulus pushes expected pixels and
// results into queues, a negedge monitor pops and compares on DUT output.
module tb_cnn_frame_feeder;
  localparam int N = 784;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] data_in;
  logic       data_valid;
  logic [3:0] core_decision = 4'h0;
  logic       core_out_valid = 1'b0;
  logic [3:0] result_data;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic       result_timeout;
  logic       busy;

  cnn_frame_feeder #(.IMG_PIXELS(N), .ADDR_W(10), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .data_in(data_in), .data_valid(data_valid),
    .core_decision(core_decision), .core_out_valid(core_out_valid),
    .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready), .result_timeout(result_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_pix [$];
  logic [4:0] exp_res [$];   // {timeout, data}
  int run = 0;
  int px_seen = 0;
  int frames_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: pixel burst, burst length and result handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      px_seen = 0;
    end else begin
      if (data_valid) begin
        if (exp_pix.size() == 0) chk("pix_unexpected", 1, 0);
        else chk("pix_data", {24'h0, data_in}, {24'h0, exp_pix.pop_front()});
        run++;
        px_seen = run;
      end else if (run != 0) begin
        chk("burst_len", run, N);
        run = 0;
        frames_done++;
      end
      if (result_valid && result_ready) begin
        if (exp_res.size() == 0) chk("res_unexpected", 1, 0);
        else chk("res_data", {27'h0, result_timeout, result_data}, {27'h0, exp_res.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mode 0: continuous, 1: toggling + random gaps; pattern selects the data
  task automatic write_frame(input int mode, input int pat, input int stop_at);
    logic [7:0] b;
    for (int i = 0; i < stop_at; i++) begin
      case (pat)
        0: b = i[7:0];
        1: b = 8'((i * 7) + 3);
        2: b = ~i[7:0];
        default: b = i[7:0] ^ 8'h5A;
      endcase
      wr_data = b; wr_valid = 1'b1;
      if (i == 0) chk("wr_ready_load", wr_ready, 1);
      exp_pix.push_back(b);
      tick();
      wr_valid = 1'b0; wr_data = 8'hAA;
      if (mode == 1 && i != stop_at - 1) begin
        if (i % 2 == 0) tick();
        if (i % 50 == 0) repeat ($urandom_range(0, 3)) tick();
      end
    end
  endtask

  // after the capturing edge of the last byte: valid on the 2nd edge
  task automatic check_latency();
    chk("lat_e0", data_valid, 0);
    chk("wr_ready_drop", wr_ready, 0);
    tick(); chk("lat_e1", data_valid, 0);
    tick(); chk("lat_e2", data_valid, 1);
  endtask

  task automatic wait_burst(input int fd0, input logic offer, input logic stray);
    logic pulsed = 1'b0;
    int n = 0;
    while (frames_done == fd0 && n < 3000) begin
      wr_valid = offer; wr_data = 8'hAA;
      core_out_valid = 1'b0;
      if (stray && !pulsed && px_seen >= 100) begin
        core_out_valid = 1'b1; core_decision = 4'd3; pulsed = 1'b1;
      end
      @(posedge clk);
      n++;
      if (offer) begin
        #1;
        if (frames_done == fd0) chk("wr_ready_stream", {wr_ready, busy}, 2'b01);
      end
    end
    wr_valid = 1'b0; core_out_valid = 1'b0;
    if (frames_done == fd0) chk("burst_timeout", 0, 1);
    #1;
  endtask

  task automatic ack_result();
    int n = 0;
    while (!result_valid && n < 200) begin tick(); n++; end
    chk("res_seen", result_valid, 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("res_drop", {result_valid, wr_ready, busy}, 3'b010);
  endtask

  initial begin
    int fd;
    // reset state
    #1;
    chk("rst_outs", {wr_ready, data_valid, result_valid, busy, result_timeout}, 5'b10000);
    chk("rst_data", {data_in, result_data}, 12'h000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // frame 1: continuous ramp, decision 7 held under backpressure
    fd = frames_done;
    exp_res.push_back({1'b0, 4'd7});
    write_frame(0, 0, N);
    check_latency();
    wait_burst(fd, 1'b0, 1'b0);
    chk("wait_no_result", result_valid, 0);
    core_decision = 4'd7; core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0; core_decision = 4'd0;
    for (int k = 0; k < 10; k++) begin
      chk("res_hold", {27'h0, result_valid, result_data}, {27'h0, 1'b1, 4'd7});
      tick();
    end
    ack_result();

    // frame 2: gapped writes, bytes offered while busy, stray decision 3
    fd = frames_done;
    exp_res.push_back({1'b0, 4'd5});
    write_frame(1, 1, N);
    check_latency();
    wait_burst(fd, 1'b1, 1'b1);
    chk("stray_ignored", result_valid, 0);
    core_decision = 4'd5; core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0;
    ack_result();

    // frame 3: reset while streaming at pixel 300
    write_frame(0, 2, N);
    begin
      int n = 0;
      while (px_seen < 300 && n < 2000) begin @(posedge clk); n++; end
      chk("reach_300", (px_seen >= 300), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_dv_low", {data_valid, result_valid}, 2'b00);
    exp_pix.delete();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst", {wr_ready, busy, data_valid}, 3'b100);

    // frame 4: full frame after abort, then no core response
    fd = frames_done;
    write_frame(0, 3, N);
    check_latency();
    wait_burst(fd, 1'b0, 1'b0);
    // now one edge into WAIT
`ifdef FEEDER_TIMEOUT_EN
    exp_res.push_back({1'b1, 4'hF});
    repeat (98) tick();
    chk("tmo_early", result_valid, 0);
    tick();
    chk("tmo_fire", {27'h0, result_valid, result_data}, {27'h0, 1'b1, 4'hF});
    chk("tmo_flag", result_timeout, 1);
    ack_result();
`else
    repeat (1000) tick();
    chk("no_tmo", {result_valid, result_timeout, busy}, 3'b001);
`endif
    chk("queues_empty", exp_pix.size() + exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
